counter_nbit_updown: RTL and testbench

- Parametrised successor to the team's fixed 4-bit loadable up-counter.
- Adds configurable width, up/down direction, count enable, runtime modulo limit, wrap/saturate mode, synchronous clear, terminal-count and compare outputs, and a sticky overflow flag.
- Used as a general event/timer counter in datapath and control blocks, e.g. frame counters, timeouts and address generators.

---
 rtl/counter_nbit_updown.sv | 101 ++++++++++
 tb/tb_counter_nbit_updown.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_nbit_updown.sv
// Parametrised up/down event counter with a runtime modulo limit.
// Offers wrap or saturate behaviour at the limit, synchronous clear and load,
// terminal-count and compare outputs, and a sticky overflow flag.
// Update priority on each clock edge is clr, then load, then en.
module counter_nbit_updown #(
  parameter int          WIDTH     = 8,
  parameter int          SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             at_term,
  output logic             wrap,
  output logic             match,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] RESET_CNT = RESET_VAL[WIDTH-1:0];
  localparam bit               SAT       = (SATURATE != 0);

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             next_ovf;
  logic             ovf_event;

  // At the terminal value for the current direction; purely a function of
  // the registered count and the present up/limit inputs.
  assign at_term = (up && (count >= limit)) || (!up && (count == '0));

  // Next-state selection: clr beats load beats en. A step that runs past the
  // limit (or below zero) either wraps or is held, and in both cases it is
  // flagged as an overflow event. A loaded value above limit is kept as-is
  // until the next enabled up-step, which then wraps or clamps it.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    ovf_event  = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_data;
    end else if (en) begin
      if (up) begin
        if (count < limit) begin
          next_count = count + 1'b1;
        end else begin
          next_count = SAT ? limit : '0;
          next_wrap  = 1'b1;
          ovf_event  = 1'b1;
        end
      end else begin
        if (count != '0) begin
          next_count = count - 1'b1;
        end else begin
          next_count = SAT ? '0 : limit;
          next_wrap  = 1'b1;
          ovf_event  = 1'b1;
        end
      end
    end
  end

  // Sticky overflow: clr wins over everything, a new overflow event wins over
  // ovf_clr so an event is never lost in the cycle it is being cleared.
  always_comb begin
    next_ovf = ovf_sticky;
    if (clr) begin
      next_ovf = 1'b0;
    end else if (ovf_event) begin
      next_ovf = 1'b1;
    end else if (ovf_clr) begin
      next_ovf = 1'b0;
    end
  end

  // State and registered outputs; match compares the next count so that it
  // lines up with the count value it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= RESET_CNT;
      wrap       <= 1'b0;
      match      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count      <= next_count;
      wrap       <= next_wrap;
      match      <= (next_count == cmp_val);
      ovf_sticky <= next_ovf;
    end
  end

endmodule

// File: tb/tb_counter_nbit_updown.sv
// Self-checking bench for counter_nbit_updown. Two 4-bit instances share the
// same stimulus, one wrapping and one saturating, and both are compared each
// cycle against a behavioural model kept in plain integers.
module tb_counter_nbit_updown;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       load;
  logic [3:0] load_data;
  logic       en;
  logic       up;
  logic [3:0] limit;
  logic [3:0] cmp_val;
  logic       ovf_clr;

  logic [3:0] count0, count1;
  logic       at_term0, at_term1;
  logic       wrap0, wrap1;
  logic       match0, match1;
  logic       ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = wrapping instance, 1 = saturating instance.
  int m_count[2];
  int m_wrap[2];
  int m_match[2];
  int m_ovf[2];

  counter_nbit_updown #(.WIDTH(4), .SATURATE(0), .RESET_VAL(5)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_data(load_data),
    .en(en), .up(up), .limit(limit), .cmp_val(cmp_val), .ovf_clr(ovf_clr),
    .count(count0), .at_term(at_term0), .wrap(wrap0), .match(match0),
    .ovf_sticky(ovf0)
  );

  counter_nbit_updown #(.WIDTH(4), .SATURATE(1), .RESET_VAL(5)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_data(load_data),
    .en(en), .up(up), .limit(limit), .cmp_val(cmp_val), .ovf_clr(ovf_clr),
    .count(count1), .at_term(at_term1), .wrap(wrap1), .match(match1),
    .ovf_sticky(ovf1)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      m_count[s] = 5;
      m_wrap[s]  = 0;
      m_match[s] = 0;
      m_ovf[s]   = 0;
    end
  endtask

  // One clock edge of the counter as the behaviour is described in words:
  // going past the top (or below zero) is an overflow that either wraps or
  // holds depending on the mode.
  task automatic modelEdge();
    for (int s = 0; s < 2; s++) begin
      int c;
      int lim;
      int ev;
      c   = m_count[s];
      lim = int'(limit);
      ev  = 0;
      if (clr) c = 0;
      else if (load) c = int'(load_data);
      else if (en) begin
        if (up) begin
          if (c < lim) c = c + 1;
          else begin
            c  = (s == 1) ? lim : 0;
            ev = 1;
          end
        end else begin
          if (c > 0) c = c - 1;
          else begin
            c  = (s == 1) ? 0 : lim;
            ev = 1;
          end
        end
      end
      if (clr) m_ovf[s] = 0;
      else if (ev != 0) m_ovf[s] = 1;
      else if (ovf_clr) m_ovf[s] = 0;
      m_count[s] = c;
      m_wrap[s]  = ev;
      m_match[s] = (c == int'(cmp_val)) ? 1 : 0;
    end
  endtask

  task automatic checkAll(input string step);
    for (int s = 0; s < 2; s++) begin
      int exp_term;
      exp_term = ((up && m_count[s] >= int'(limit)) || (!up && m_count[s] == 0)) ? 1 : 0;
      checkOutput($sformatf("%s/i%0d/count", step, s),
                  (s == 0) ? 32'(count0) : 32'(count1), 32'(m_count[s]));
      checkOutput($sformatf("%s/i%0d/wrap", step, s),
                  (s == 0) ? 32'(wrap0) : 32'(wrap1), 32'(m_wrap[s]));
      checkOutput($sformatf("%s/i%0d/match", step, s),
                  (s == 0) ? 32'(match0) : 32'(match1), 32'(m_match[s]));
      checkOutput($sformatf("%s/i%0d/ovf", step, s),
                  (s == 0) ? 32'(ovf0) : 32'(ovf1), 32'(m_ovf[s]));
      checkOutput($sformatf("%s/i%0d/at_term", step, s),
                  (s == 0) ? 32'(at_term0) : 32'(at_term1), 32'(exp_term));
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic applyStimulus(input string step, input logic c, input logic l,
                               input logic [3:0] ld, input logic e, input logic u,
                               input logic [3:0] lim, input logic [3:0] cv,
                               input logic oc);
    clr = c; load = l; load_data = ld; en = e; up = u;
    limit = lim; cmp_val = cv; ovf_clr = oc;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(step);
  endtask

  initial begin
    $display("[TB] start");
    reset_n = 1'b0;
    clr = 0; load = 0; load_data = 0; en = 0; up = 1;
    limit = 4'd15; cmp_val = 4'd0; ovf_clr = 0;
    modelReset();
    #12;
    checkAll("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Count up to 9, then assert reset asynchronously between edges.
    applyStimulus("ld7", 0, 1, 4'd7, 0, 1, 4'd15, 4'd0, 0);
    applyStimulus("up8", 0, 0, 4'd0, 1, 1, 4'd15, 4'd0, 0);
    applyStimulus("up9", 0, 0, 4'd0, 1, 1, 4'd15, 4'd0, 0);
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkAll("async_rst");
    #2 reset_n = 1'b1;
    applyStimulus("resume6", 0, 0, 4'd0, 1, 1, 4'd15, 4'd0, 0);
    applyStimulus("resume7", 0, 0, 4'd0, 1, 1, 4'd15, 4'd0, 0);

    // Priority: clr over load over en, then load over en.
    applyStimulus("prio_all", 1, 1, 4'd3, 1, 1, 4'd15, 4'd0, 0);
    applyStimulus("prio_ld", 0, 1, 4'd3, 1, 1, 4'd15, 4'd0, 0);

    // Wrap up at limit 9 from zero.
    applyStimulus("wrap_clr", 1, 0, 4'd0, 0, 1, 4'd9, 4'd0, 0);
    for (int i = 0; i < 12; i++)
      applyStimulus($sformatf("wrap_up%0d", i), 0, 0, 4'd0, 1, 1, 4'd9, 4'd0, 0);

    // Down-count below zero from 2.
    applyStimulus("dn_ld2", 0, 1, 4'd2, 0, 0, 4'd9, 4'd0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("dn%0d", i), 0, 0, 4'd0, 1, 0, 4'd9, 4'd0, 0);

    // Loaded value above limit, then counting up.
    applyStimulus("hi_ld12", 0, 1, 4'd12, 0, 1, 4'd5, 4'd0, 0);
    applyStimulus("hi_up0", 0, 0, 4'd0, 1, 1, 4'd5, 4'd0, 0);
    applyStimulus("hi_up1", 0, 0, 4'd0, 1, 1, 4'd5, 4'd0, 0);

    // Compare and sticky overflow handling.
    applyStimulus("cmp_clr", 1, 0, 4'd0, 0, 1, 4'd9, 4'd4, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("cmp_up%0d", i), 0, 0, 4'd0, 1, 1, 4'd9, 4'd4, 0);
    applyStimulus("ovf_set_clr", 0, 0, 4'd0, 1, 1, 4'd0, 4'd4, 1);
    applyStimulus("ovf_set_clr2", 0, 0, 4'd0, 1, 1, 4'd0, 4'd4, 1);
    applyStimulus("ovf_clr_only", 0, 0, 4'd0, 0, 1, 4'd0, 4'd4, 1);

    // Randomised traffic with occasional clear/load/ovf_clr.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($sformatf("rnd%0d", i),
                    ($urandom_range(15) == 0), ($urandom_range(7) == 0),
                    4'($urandom), ($urandom_range(3) != 0), 1'($urandom),
                    4'($urandom), 4'($urandom), ($urandom_range(7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
